// File: rtl/rgb_arb_pkg.sv
// rgb_arb_pkg: shared types and constants for the RGB LED arbiter.
//   state_t    - arbiter FSM state (2-bit, S_IDLE is the reset/zero encoding)
//   RGB_OFF    - blank LED drive {r,g,b}
//   RGB_ERR    - LED drive shown for one cycle when the FSM is in S_ERROR
//   cnt_width  - width of a counter that must reach max(hold, gap)-1
package rgb_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_GAP   = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  localparam logic [2:0] RGB_OFF = 3'b000;
  localparam logic [2:0] RGB_ERR = 3'b111;

  // One counter serves both the hold and the gap phase, so it is sized for
  // the longer of the two; never narrower than one bit.
  function automatic int cnt_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rgb_led_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority picker.
//   req        - request vector, one bit per requester
//   last_owner - index of the most recently granted requester
//   found      - at least one request is set
//   winner     - first requester at or after last_owner+1 (wrapping) with req set;
//                last_owner itself is searched last, so it only wins again when alone
module rr_picker
  import rgb_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_owner,
  output logic             found,
  output logic [ID_W-1:0]  winner
);

  // NOTE: every always_comb output gets a default before any conditional
  // assignment so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (int'(last_owner) + k) % N_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rgb_led_arbiter.sv
// rgb_led_arbiter: shares one RGB LED between N_REQ status sources using
// round-robin ownership, a minimum display time under contention and a blank
// gap between consecutive owners.
//   clk      - clock
//   rst      - synchronous active-high reset
//   req      - per-requester level-sensitive request
//   colors   - colour of requester i at [3i+2:3i], {r,g,b}
//   grant    - one-hot current owner, zero when nobody owns the LED
//   rgb      - LED drive (owner's live colour in HOLD, off in IDLE/GAP, white in ERROR)
//   owner_id - index of current owner, meaningful while grant != 0
//   busy     - high in every state except S_IDLE
module rgb_led_arbiter
  import rgb_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int HOLD_TICKS = 250,
  parameter int GAP_TICKS  = 25,
  localparam int ID_W      = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [3*N_REQ-1:0] colors,
  output logic [N_REQ-1:0]   grant,
  output logic [2:0]         rgb,
  output logic [ID_W-1:0]    owner_id,
  output logic               busy
);

  localparam int CNT_W = cnt_width(HOLD_TICKS, GAP_TICKS);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [ID_W-1:0]  last_owner;

  logic             found;
  logic [ID_W-1:0]  winner;
  logic [N_REQ-1:0] owner_hot;
  logic             other_req;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req        (req),
    .last_owner (last_owner),
    .found      (found),
    .winner     (winner)
  );

  assign owner_hot = N_REQ'(1) << owner_id;
  assign other_req = |(req & ~owner_hot);

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      counter    <= '0;
      owner_id   <= '0;
      last_owner <= ID_W'(N_REQ - 1);
    end else begin
      case (state)
        S_IDLE: begin
          counter <= '0;
          if (found) begin
            state      <= S_HOLD;
            owner_id   <= winner;
            last_owner <= winner;
          end
        end

        S_HOLD: begin
          // Release and expiry both lead to the same single transition.
          if (!req[owner_id] || (counter == HOLD_LAST && other_req)) begin
            state   <= S_GAP;
            counter <= '0;
          end else if (counter != HOLD_LAST) begin
            counter <= counter + 1'b1;
          end
        end

        S_GAP: begin
          if (counter == GAP_LAST) begin
            counter <= '0;
            if (found) begin
              state      <= S_HOLD;
              owner_id   <= winner;
              last_owner <= winner;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            counter <= counter + 1'b1;
          end
        end

        S_ERROR: begin
          state   <= S_IDLE;
          counter <= '0;
        end

        default: state <= S_ERROR;
      endcase
    end
  end

  // Outputs decode registered state only; colour follows the owner's input live.
  always_comb begin
    grant = '0;
    rgb   = RGB_OFF;
    case (state)
      S_HOLD: begin
        grant = owner_hot;
        rgb   = colors[3*owner_id +: 3];
      end
      S_ERROR: rgb = RGB_ERR;
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// tb_rgb_led_arbiter: scoreboard bench for rgb_led_arbiter (N_REQ=4,
// HOLD_TICKS=4, GAP_TICKS=2). The stimulus process advances a reference
// model of ownership/time-served and queues the expected outputs of each
// cycle; a separate monitor compares them against the DUT at the falling edge.
module tb_rgb_led_arbiter;

  localparam int N = 4;
  localparam int H = 4;
  localparam int G = 2;

  localparam int PH_IDLE = 0;
  localparam int PH_HOLD = 1;
  localparam int PH_GAP  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [3*N-1:0] colors;
  logic [N-1:0]  grant;
  logic [2:0]    rgb;
  logic [1:0]    owner_id;
  logic          busy;

  rgb_led_arbiter #(.N_REQ(N), .HOLD_TICKS(H), .GAP_TICKS(G)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .colors   (colors),
    .grant    (grant),
    .rgb      (rgb),
    .owner_id (owner_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] grant;
    logic [2:0]   rgb;
    logic         busy;
    logic [1:0]   owner;
    bit           chk_owner;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the LED, which phase we are in, and how many
  // cycles have already been spent in that phase.
  int m_phase, m_t, m_owner, m_last;
  bit m_fresh;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int rr_winner(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic give_to(input int w);
    m_phase = PH_HOLD;
    m_t     = 0;
    m_owner = w;
    m_last  = w;
    m_fresh = 1'b0;
  endtask

  // Advance the model across one clock edge given the inputs sampled there.
  task automatic model_step(input logic r_rst, input logic [N-1:0] r);
    int w;
    bit others;
    if (r_rst) begin
      m_phase = PH_IDLE; m_t = 0; m_owner = 0; m_last = N - 1; m_fresh = 1'b1;
      return;
    end
    w = rr_winner(r, m_last);
    others = 1'b0;
    for (int i = 0; i < N; i++) if (i != m_owner && r[i]) others = 1'b1;
    case (m_phase)
      PH_IDLE: if (w >= 0) give_to(w);
      PH_HOLD: begin
        // Served m_t+1 cycles so far; contention only ends it once H are served.
        if (!r[m_owner] || (m_t + 1 >= H && others)) begin
          m_phase = PH_GAP; m_t = 0;
        end else m_t++;
      end
      default: begin
        if (m_t + 1 == G) begin
          if (w >= 0) give_to(w);
          else begin m_phase = PH_IDLE; m_t = 0; end
        end else m_t++;
      end
    endcase
  endtask

  task automatic push_expect();
    exp_t e;
    e.grant     = (m_phase == PH_HOLD) ? (N'(1) << m_owner) : '0;
    e.rgb       = (m_phase == PH_HOLD) ? colors[3*m_owner +: 3] : 3'b000;
    e.busy      = (m_phase != PH_IDLE);
    e.owner     = 2'(m_owner);
    e.chk_owner = (m_phase == PH_HOLD) || m_fresh;
    sb.push_back(e);
  endtask

  task automatic cycle(input logic r_rst, input logic [N-1:0] r_req, input logic [3*N-1:0] r_col);
    @(posedge clk);
    model_step(rst, req);
    #2;
    rst    = r_rst;
    req    = r_req;
    colors = r_col;
    push_expect();
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("grant", 32'(grant), 32'(e.grant));
      check("rgb",   32'(rgb),   32'(e.rgb));
      check("busy",  32'(busy),  32'(e.busy));
      if (e.chk_owner) check("owner_id", 32'(owner_id), 32'(e.owner));
    end
  end

  logic [N-1:0]   r;
  logic [3*N-1:0] col;

  initial begin
    rst = 1'b1; req = '0; colors = '0;
    m_phase = PH_IDLE; m_t = 0; m_owner = 0; m_last = N - 1; m_fresh = 1'b1;
    // colors[0]=100, colors[1]=010, colors[2]=011, colors[3]=001
    col = {3'b001, 3'b011, 3'b010, 3'b100};

    cycle(1'b1, '0, col);
    cycle(1'b1, '0, col);

    // Single requester held well past the hold time: no gap expected.
    repeat (21) cycle(1'b0, 4'b0001, col);

    // Contention between 0 and 1.
    cycle(1'b1, '0, col);
    repeat (12) cycle(1'b0, 4'b0011, col);

    // Early release: owner 0 drops in its second hold cycle.
    cycle(1'b1, '0, col);
    cycle(1'b0, 4'b0011, col);
    cycle(1'b0, 4'b0011, col);
    repeat (7) cycle(1'b0, 4'b0010, col);

    // Fairness with everyone requesting.
    cycle(1'b1, '0, col);
    repeat (30) cycle(1'b0, 4'b1111, col);

    // Late arrival after expiry.
    cycle(1'b1, '0, col);
    repeat (11) cycle(1'b0, 4'b0001, col);
    repeat (6) cycle(1'b0, 4'b0101, col);

    // Reset while owner 2 holds, then requesters 0 and 2.
    cycle(1'b1, '0, col);
    repeat (3) cycle(1'b0, 4'b0100, col);
    cycle(1'b1, 4'b0101, col);
    repeat (8) cycle(1'b0, 4'b0101, col);

    // Randomized traffic: slowly changing requests, changing colours, rare resets.
    r = '0;
    repeat (3000) begin
      if ($urandom_range(5) == 0) r[$urandom_range(N - 1)] = ~r[$urandom_range(N - 1)];
      if ($urandom_range(11) == 0) col = 12'($urandom);
      cycle(($urandom_range(249) == 0), r, col);
    end

    repeat (3) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
